// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests instructions from instruction
// memory over a valid/ready handshake and fills the 64-bit IF/ID register.
// It honours decode's pcHOLD stall. A taken branch flushes the wrong-path
// fetch and redirects the PC.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcHOLD,
    input  logic        BranchControlSignal,
    input  logic [31:0] BranchTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [63:0] IFIDReg,
    output logic        IFIDValid
);

    typedef enum logic [1:0] {
        FETCH    = 2'd0,  // requesting at PC
        HOLD_BUF = 2'd1,  // fetched word parked while decode stalls
        DROP     = 2'd2   // redirect pending, old request still outstanding
    } state_e;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
    localparam logic [63:0] BUBBLE           = {NOP_INSTR, 32'h0000_0000};

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] redirect_q;
    logic [63:0] buf_q;
    logic [63:0] ifid_q;
    logic        ifid_valid_q;
    logic        req_q;

    logic        br;
    logic        xfer;
    logic [31:0] br_target;
    logic [31:0] pc_plus4;

    // A branch raised during a stall is ignored; decode presents it again.
    assign br        = BranchControlSignal & ~pcHOLD;
    assign xfer      = req_q & imem_ready;
    assign br_target = {BranchTarget[31:2], 2'b00};
    assign pc_plus4  = pc_q + 32'd4;

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign IFIDReg   = ifid_q;
    assign IFIDValid = ifid_valid_q;

    // Fetch FSM with registered request, PC, IF/ID register, buffer and redirect.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC_ALIGNED;
            redirect_q   <= 32'h0000_0000;
            buf_q        <= 64'h0;
            ifid_q       <= BUBBLE;
            ifid_valid_q <= 1'b0;
            req_q        <= 1'b0;
        end else begin
            // Request is raised in every state except HOLD_BUF. The HOLD_BUF
            // branches below override this default.
            req_q <= 1'b1;
            case (state_q)
                FETCH: begin
                    if (br) begin
                        ifid_q       <= BUBBLE;
                        ifid_valid_q <= 1'b0;
                        if (xfer) begin
                            pc_q <= br_target;
                        end else begin
                            // Request must not be withdrawn; drop its data later.
                            redirect_q <= br_target;
                            state_q    <= DROP;
                        end
                    end else if (xfer) begin
                        pc_q <= pc_plus4;
                        if (pcHOLD) begin
                            buf_q   <= {imem_rdata, pc_plus4};
                            state_q <= HOLD_BUF;
                            req_q   <= 1'b0;
                        end else begin
                            ifid_q       <= {imem_rdata, pc_plus4};
                            ifid_valid_q <= 1'b1;
                        end
                    end else if (!pcHOLD) begin
                        ifid_q       <= BUBBLE;
                        ifid_valid_q <= 1'b0;
                    end
                end

                HOLD_BUF: begin
                    if (br) begin
                        pc_q         <= br_target;
                        ifid_q       <= BUBBLE;
                        ifid_valid_q <= 1'b0;
                        state_q      <= FETCH;
                    end else if (!pcHOLD) begin
                        ifid_q       <= buf_q;
                        ifid_valid_q <= 1'b1;
                        state_q      <= FETCH;
                    end else begin
                        req_q <= 1'b0;
                    end
                end

                DROP: begin
                    if (xfer) begin
                        // Latest branch wins if another one arrives on the drop edge.
                        pc_q    <= br ? br_target : redirect_q;
                        state_q <= FETCH;
                    end else if (br) begin
                        redirect_q <= br_target;
                    end
                    if (!pcHOLD) begin
                        ifid_q       <= BUBBLE;
                        ifid_valid_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

endmodule
